// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory block port between the instruction
// cache (reads only) and the data cache (reads and writebacks). Requests are
// serialised through IDLE -> ISSUE -> WAIT -> RELEASE. Each requester is
// stalled until its transfer completes, and read blocks are returned in
// per-port registers.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests. When it is undefined, the data cache always wins.
module mem_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int BLOCK_W = 32
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               I_READ,
   input  logic [ADDR_W-1:0]  I_ADDRESS,
   output logic [BLOCK_W-1:0] I_READDATA,
   output logic               I_BUSYWAIT,
   input  logic               D_READ,
   input  logic               D_WRITE,
   input  logic [ADDR_W-1:0]  D_ADDRESS,
   input  logic [BLOCK_W-1:0] D_WRITEDATA,
   output logic [BLOCK_W-1:0] D_READDATA,
   output logic               D_BUSYWAIT,
   output logic               MEM_READ,
   output logic               MEM_WRITE,
   output logic [ADDR_W-1:0]  MEM_ADDRESS,
   output logic [BLOCK_W-1:0] MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0] MEM_READDATA,
   input  logic               MEM_BUSYWAIT
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t               state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 last_owner_q, last_owner_d;
   logic                 op_write_q, op_write_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BLOCK_W-1:0]   wdata_q, wdata_d;
   logic                 mem_read_q, mem_read_d;
   logic                 mem_write_q, mem_write_d;
   logic [BLOCK_W-1:0]   i_rdata_q, i_rdata_d;
   logic [BLOCK_W-1:0]   d_rdata_q, d_rdata_d;

   logic                 i_req, d_req, grant_to_d, xfer_active;

   assign i_req = I_READ;
   assign d_req = D_READ | D_WRITE;

   // A transfer is committed to memory from ISSUE until its completion in WAIT.
   assign xfer_active = (state_q == S_ISSUE) || (state_q == S_WAIT);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // On a tie, the port that was not served last wins, so neither port starves.
   assign grant_to_d = (i_req && d_req) ? (last_owner_q == OWN_I) : d_req;
`else
   // Fixed priority: the data cache always wins.
   assign grant_to_d = d_req;
`endif

   // State register. Reset aborts any transfer in flight.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. ISSUE always lasts one cycle so memory can raise busywait.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (i_req || d_req) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT:    if (!MEM_BUSYWAIT) state_d = S_RELEASE;
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output/latch logic: next values for the registered strobes, the latched
   // request and the readdata registers.
   always_comb begin
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      op_write_d   = op_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (grant_to_d) begin
               // D_READ together with D_WRITE is treated as a writeback.
               owner_d     = OWN_D;
               addr_d      = D_ADDRESS;
               wdata_d     = D_WRITEDATA;
               op_write_d  = D_WRITE;
               mem_write_d = D_WRITE;
               mem_read_d  = !D_WRITE;
            end else if (i_req) begin
               owner_d     = OWN_I;
               addr_d      = I_ADDRESS;
               op_write_d  = 1'b0;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
            end
         end
         S_WAIT: begin
            if (!MEM_BUSYWAIT) begin
               mem_read_d   = 1'b0;
               mem_write_d  = 1'b0;
               last_owner_d = owner_q;
               if (!op_write_q) begin
                  if (owner_q == OWN_D) begin
                     d_rdata_d = MEM_READDATA;
                  end else begin
                     i_rdata_d = MEM_READDATA;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Control and latched-request registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         owner_q      <= OWN_D;
         last_owner_q <= OWN_I;
         op_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         op_write_q   <= op_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   // Readdata registers: a reset that aborts a transfer keeps the last block
   // delivered to each cache. An idle reset clears them.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         if (!xfer_active) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
         end
      end else begin
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = addr_q;
   assign MEM_WRITEDATA = wdata_q;
   assign I_READDATA    = i_rdata_q;
   assign D_READDATA    = d_rdata_q;

   // The owner is released for exactly the one RELEASE cycle.
   assign I_BUSYWAIT = i_req & !((state_q == S_RELEASE) && (owner_q == OWN_I));
   assign D_BUSYWAIT = d_req & !((state_q == S_RELEASE) && (owner_q == OWN_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. The memory side is driven by the bench.
// Expected grant order depends on MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        I_READ;
   logic [5:0]  I_ADDRESS;
   logic [31:0] I_READDATA;
   logic        I_BUSYWAIT;
   logic        D_READ;
   logic        D_WRITE;
   logic [5:0]  D_ADDRESS;
   logic [31:0] D_WRITEDATA;
   logic [31:0] D_READDATA;
   logic        D_BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   int n_assert = 0;
   int n_fail   = 0;

   mem_arbiter #(.ADDR_W(6), .BLOCK_W(32)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
      .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
      .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered in the ISSUE cycle and returns in the RELEASE cycle.
   task automatic run_mem(input int busy, input logic [31:0] rd, input logic er,
                          input logic ew, input logic [5:0] ea, input logic [31:0] ewd);
      chk("issue_read", MEM_READ, er);
      chk("issue_write", MEM_WRITE, ew);
      chk("issue_addr", MEM_ADDRESS, ea);
      if (ew) chk("issue_wdata", MEM_WRITEDATA, ewd);
      MEM_BUSYWAIT = 1'b1;
      tick;
      for (int k = 0; k < busy; k++) begin
         chk("wait_read", MEM_READ, er);
         chk("wait_write", MEM_WRITE, ew);
         chk("wait_addr", MEM_ADDRESS, ea);
         if (ew) chk("wait_wdata", MEM_WRITEDATA, ewd);
         tick;
      end
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = rd;
      chk("last_wait_read", MEM_READ, er);
      chk("last_wait_write", MEM_WRITE, ew);
      tick;
      MEM_READDATA = 32'h0BAD_F00D;
      chk("release_read", MEM_READ, 1'b0);
      chk("release_write", MEM_WRITE, 1'b0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] i_exp, d_exp;
      logic        own_exp [3];
      logic [31:0] gdat [3];
      gdat[0] = 32'hA1A1_A1A1; gdat[1] = 32'hB2B2_B2B2; gdat[2] = 32'hC3C3_C3C3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      own_exp[0] = 1'b1; own_exp[1] = 1'b0; own_exp[2] = 1'b1;
`else
      own_exp[0] = 1'b1; own_exp[1] = 1'b1; own_exp[2] = 1'b1;
`endif

      RESET = 1'b1; I_READ = 1'b0; I_ADDRESS = '0; D_READ = 1'b0; D_WRITE = 1'b0;
      D_ADDRESS = '0; D_WRITEDATA = '0; MEM_READDATA = '0; MEM_BUSYWAIT = 1'b0;
      tick; tick; tick;
      // Reset state; busywait follows the request even under reset.
      chk("rst_mem_read", MEM_READ, 1'b0);
      chk("rst_mem_write", MEM_WRITE, 1'b0);
      chk("rst_mem_addr", MEM_ADDRESS, 6'h00);
      chk("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
      chk("rst_i_rdata", I_READDATA, 32'h0);
      chk("rst_d_rdata", D_READDATA, 32'h0);
      chk("rst_i_busy_idle", I_BUSYWAIT, 1'b0);
      chk("rst_d_busy_idle", D_BUSYWAIT, 1'b0);
      I_READ = 1'b1; #1;
      chk("rst_i_busy_req", I_BUSYWAIT, 1'b1);
      I_READ = 1'b0;
      tick;
      RESET = 1'b0;
      MEM_READDATA = 32'h0BAD_F00D;
      tick;

      // I-only read, 5 memory busy cycles; address frozen after grant.
      I_READ = 1'b1; I_ADDRESS = 6'h05; #1;
      chk("t1_i_busy_req", I_BUSYWAIT, 1'b1);
      chk("t1_no_read_yet", MEM_READ, 1'b0);
      tick;
      I_ADDRESS = 6'h3F;
      run_mem(5, 32'hDEAD_BEEF, 1'b1, 1'b0, 6'h05, 32'h0);
      chk("t1_i_rdata", I_READDATA, 32'hDEAD_BEEF);
      chk("t1_i_busy_rel", I_BUSYWAIT, 1'b0);
      chk("t1_d_rdata", D_READDATA, 32'h0);
      I_READ = 1'b0;
      tick;
      chk("t1_idle_read", MEM_READ, 1'b0);
      chk("t1_i_rdata_hold", I_READDATA, 32'hDEAD_BEEF);

      // D read to give D_READDATA a known value.
      D_READ = 1'b1; D_ADDRESS = 6'h03;
      tick;
      run_mem(2, 32'hCAFE_F00D, 1'b1, 1'b0, 6'h03, 32'h0);
      chk("t2_d_rdata", D_READDATA, 32'hCAFE_F00D);
      chk("t2_d_busy_rel", D_BUSYWAIT, 1'b0);
      chk("t2_i_rdata", I_READDATA, 32'hDEAD_BEEF);
      D_READ = 1'b0;
      tick;

      // D writeback; data and address frozen, D_READDATA untouched.
      D_WRITE = 1'b1; D_ADDRESS = 6'h0A; D_WRITEDATA = 32'h1234_5678;
      tick;
      D_WRITEDATA = 32'hFFFF_FFFF; D_ADDRESS = 6'h01;
      run_mem(3, 32'h5555_5555, 1'b0, 1'b1, 6'h0A, 32'h1234_5678);
      chk("t3_d_rdata_kept", D_READDATA, 32'hCAFE_F00D);
      chk("t3_d_busy_rel", D_BUSYWAIT, 1'b0);
      D_WRITE = 1'b0;
      tick;
      chk("t3_d_busy_idle", D_BUSYWAIT, 1'b0);

      // Reset during WAIT of a D read.
      D_READ = 1'b1; D_ADDRESS = 6'h07;
      tick;
      MEM_BUSYWAIT = 1'b1;
      tick;
      tick;
      chk("t4_wait_read", MEM_READ, 1'b1);
      MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h7777_7777; RESET = 1'b1;
      tick;
      chk("t4_rst_read", MEM_READ, 1'b0);
      chk("t4_rst_write", MEM_WRITE, 1'b0);
      chk("t4_rst_d_rdata", D_READDATA, 32'hCAFE_F00D);
      chk("t4_rst_d_busy", D_BUSYWAIT, 1'b1);
      RESET = 1'b0; MEM_READDATA = 32'h0BAD_F00D;
      tick;
      run_mem(1, 32'h1357_9BDF, 1'b1, 1'b0, 6'h07, 32'h0);
      chk("t4_d_rdata_new", D_READDATA, 32'h1357_9BDF);
      chk("t4_d_busy_rel", D_BUSYWAIT, 1'b0);
      D_READ = 1'b0;
      tick;

      // Idle reset clears readdata and restarts arbitration history.
      RESET = 1'b1;
      tick; tick;
      RESET = 1'b0;
      chk("t5_rst_i_rdata", I_READDATA, 32'h0);
      chk("t5_rst_d_rdata", D_READDATA, 32'h0);
      i_exp = 32'h0; d_exp = 32'h0;

      // Simultaneous held requests: three consecutive grants.
      I_READ = 1'b1; I_ADDRESS = 6'h11; D_READ = 1'b1; D_ADDRESS = 6'h22;
      for (int g = 0; g < 3; g++) begin
         tick;
         run_mem(g, gdat[g], 1'b1, 1'b0, own_exp[g] ? 6'h22 : 6'h11, 32'h0);
         if (own_exp[g]) d_exp = gdat[g];
         else            i_exp = gdat[g];
         chk("t5_i_rdata", I_READDATA, i_exp);
         chk("t5_d_rdata", D_READDATA, d_exp);
         chk("t5_i_busy_rel", I_BUSYWAIT, own_exp[g] ? 1'b1 : 1'b0);
         chk("t5_d_busy_rel", D_BUSYWAIT, own_exp[g] ? 1'b0 : 1'b1);
         tick;
         chk("t5_i_busy_idle", I_BUSYWAIT, 1'b1);
         chk("t5_d_busy_idle", D_BUSYWAIT, 1'b1);
         chk("t5_idle_read", MEM_READ, 1'b0);
      end
      I_READ = 1'b0; D_READ = 1'b0;
      tick;
      chk("t5_quiet_read", MEM_READ, 1'b0);

      // D_READ and D_WRITE together: one write, never a read.
      D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 6'h2A; D_WRITEDATA = 32'h0F0F_0F0F;
      tick;
      run_mem(2, 32'h9999_9999, 1'b0, 1'b1, 6'h2A, 32'h0F0F_0F0F);
      chk("t6_d_rdata_kept", D_READDATA, d_exp);
      chk("t6_d_busy_rel", D_BUSYWAIT, 1'b0);
      D_READ = 1'b0; D_WRITE = 1'b0;
      tick;
      chk("t6_idle_read", MEM_READ, 1'b0);
      chk("t6_idle_write", MEM_WRITE, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
